// File: rtl/ts_clk_pkg.sv
// Shared mode encoding and default phase increments for the TS byte clock generator.
package ts_clk_pkg;

  localparam int MODE_W   = 2;
  localparam int DEF_MOD  = 100;
  localparam int DEF_INC0 = 54;
  localparam int DEF_INC1 = 50;
  localparam int DEF_INC2 = 27;
  localparam int DEF_INC3 = 0;

  typedef enum logic [MODE_W-1:0] {
    MODE_27M  = 2'd0,
    MODE_25M  = 2'd1,
    MODE_13M5 = 2'd2,
    MODE_STOP = 2'd3
  } mode_t;

  function automatic int mode_inc(input mode_t mode, input int inc0, input int inc1,
                                  input int inc2, input int inc3);
    case (mode)
      MODE_27M:  mode_inc = inc0;
      MODE_25M:  mode_inc = inc1;
      MODE_13M5: mode_inc = inc2;
      default:   mode_inc = inc3;
    endcase
  endfunction

endpackage

// File: rtl/ts_phase_acc.sv
// Modulo-MOD phase accumulator; wrap is a combinational strobe for the add about to be registered.
module ts_phase_acc #(
  parameter int MOD   = 100,
  parameter int ACC_W = 8
) (
  input  logic             clk2,
  input  logic             rst,
  input  logic             en,
  input  logic [ACC_W-1:0] inc,
  output logic             wrap
);

  localparam logic [ACC_W-1:0] MOD_V = ACC_W'(MOD);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;

  // acc < MOD and inc <= MOD, so the sum never exceeds 2*MOD-1 and fits in ACC_W bits
  assign sum  = acc + inc;
  assign wrap = en && (sum >= MOD_V);

  always_ff @(posedge clk2) begin
    if (rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= wrap ? (sum - MOD_V) : sum;
    end
  end

endmodule

// File: rtl/ts_frac_clock_divider.sv
// Fractional MPEG2-TS byte clock generator: clk_out toggles and tick pulses on each accumulator wrap.
// Optional saturating tick counter enabled by defining TS_CLKDIV_TICKCNT_EN.
module ts_frac_clock_divider
  import ts_clk_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int MOD   = DEF_MOD,
  parameter int ACC_W = 8,
  parameter int INC0  = DEF_INC0,
  parameter int INC1  = DEF_INC1,
  parameter int INC2  = DEF_INC2,
  parameter int INC3  = DEF_INC3
) (
  input  logic              clk2,
  input  logic              rst,
  input  logic [N_CH-1:0]   valid,
  input  logic [MODE_W-1:0] mux_ctrl,
  output logic              clk_out,
  output logic              tick,
  output logic [MODE_W-1:0] active_mode,
  output logic              mode_pending
`ifdef TS_CLKDIV_TICKCNT_EN
  ,
  output logic [31:0]       tick_count
`endif
);

  if (INC0 > MOD || INC1 > MOD || INC2 > MOD || INC3 > MOD) begin : g_inc_range_check
    $error("ts_frac_clock_divider: every INCn must be <= MOD");
  end
  if ((2 ** ACC_W) <= (2 * MOD - 1)) begin : g_acc_width_check
    $error("ts_frac_clock_divider: ACC_W too narrow for 2*MOD-1");
  end

  mode_t            cur_mode;
  mode_t            req_mode;
  logic             en;
  logic             wrap;
  logic             apply_mode;
  logic [ACC_W-1:0] inc;

  assign en           = |valid;
  assign req_mode     = mode_t'(mux_ctrl);
  assign inc          = ACC_W'(mode_inc(cur_mode, INC0, INC1, INC2, INC3));
  assign active_mode  = cur_mode;
  assign mode_pending = (req_mode != cur_mode);

  // Switch only when no edge can be cut short: idle, frozen, or a falling wrap starting a low phase
  assign apply_mode = !en || (inc == '0) || (wrap && clk_out);

  ts_phase_acc #(
    .MOD   (MOD),
    .ACC_W (ACC_W)
  ) u_phase_acc (
    .clk2 (clk2),
    .rst  (rst),
    .en   (en),
    .inc  (inc),
    .wrap (wrap)
  );

  always_ff @(posedge clk2) begin
    if (rst) begin
      cur_mode <= MODE_27M;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
    end else begin
      tick <= wrap;
      if (wrap) begin
        clk_out <= ~clk_out;
      end
      if (apply_mode) begin
        cur_mode <= req_mode;
      end
    end
  end

`ifdef TS_CLKDIV_TICKCNT_EN
  always_ff @(posedge clk2) begin
    if (rst) begin
      tick_count <= '0;
    end else if (tick && (tick_count != '1)) begin
      tick_count <= tick_count + 32'd1;
    end
  end
`endif

endmodule
